cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss handler directly upstream of the cache data array: on a miss it fetches the 8-word block
//  from multi-cycle main memory and writes each returned word into the data array.
//  Drives one-hot block/word enables, write strobe and DataIn, then pulses the tag-array write.
//  Stalls the pipeline for the whole fill. Direct-mapped: 128 sets x 8 words x 16 bits.
// PARAMETERS
//  ADDR_W      16   byte address width
//  WORDS       8    words per block (offset = addr[3:1], addr[0] = byte-in-word)
//  SETS        128  blocks in data array (index = addr[10:4])
//  TAG_W       5    tag width (addr[15:11])
// PORTS
//  clk                in   1    clock, rising edge
//  rst                in   1    asynchronous, active-low reset
//  miss_detected      in   1    cache miss this cycle (level; sampled in IDLE only)
//  miss_address       in   16   faulting byte address
//  memory_data        in   16   read data returned by memory
//  memory_data_valid  in   1    memory_data valid this cycle; one word per pulse, in issue order
//  fsm_busy           out  1    stall request to pipeline
//  mem_en             out  1    issue a memory read this cycle
//  memory_address     out  16   read address, block-aligned base + offset
//  write_data_array   out  1    data array write strobe (to Write)
//  block_enable       out  128  one-hot set select (to BlockEnable)
//  word_enable        out  8    one-hot word select (to WordEnable)
//  data_out           out  16   fill data (to DataIn)
//  write_tag_array    out  1    one-cycle tag/valid write strobe
//  tag_out            out  5    tag to write
//  fill_done          out  1    one-cycle pulse, block fill complete
// BEHAVIOUR
//  States: IDLE, FILL. Reset (rst=0, async) -> IDLE, issue_cnt=0, recv_cnt=0, miss_addr_q=0;
//   all outputs 0 except block_enable = one-hot(0) (bit 0), which is harmless because
//   write_data_array=0.
//  IDLE: miss_detected=1 -> latch miss_addr_q={miss_address[15:4],4'b0}, go FILL next edge.
//   fsm_busy = FILL | (IDLE & miss_detected): stall is combinational in the miss cycle.
//  FILL issue: mem_en=1 while issue_cnt<8; memory_address = {miss_addr_q[15:4], issue_cnt[2:0], 1'b0}.
//   issue_cnt increments each cycle until 8, then holds. Issue never waits on returns; memory is pipelined.
//  FILL receive: when memory_data_valid=1:
//   - write_data_array=1, data_out=memory_data, word_enable=onehot(recv_cnt);
//   - block_enable=onehot(miss_addr_q[10:4]);
//   - recv_cnt increments.
//   These outputs are combinational from valid, so the write lands on the same edge.
//  Completion: valid with recv_cnt==7 -> write_tag_array=1, tag_out=miss_addr_q[15:11], fill_done=1,
//   all in that cycle; next state IDLE, counters cleared. fsm_busy stays 1 through that cycle.
//  Tag is written only after the last word, so a partially filled line is never marked valid.
//  Outside receive cycles: write_data_array=0, word_enable=0, data_out=0.
//  Boundaries:
//   - miss_detected in FILL: ignored; no re-latch.
//   - memory_data_valid in IDLE: ignored, no strobes.
//   - Valid may arrive while issue_cnt<8 (overlap); issue and receive proceed the same cycle.
//   - A new miss in the cycle after fill_done is accepted normally (back-to-back fills).
//   - Reset mid-fill: immediate IDLE; no tag write; line keeps its prior tag/valid state.
//     Words already written are stale but unreachable until a refill.
//   - recv_cnt is 3 bits; the wrap 7->0 coincides with the FILL->IDLE transition.
// STRUCTURE
//  Shared header cache_defs.vh: localparams WORDS, SETS, TAG_W, OFFSET/INDEX/TAG bit ranges,
//   state encodings (IDLE=1'b0, FILL=1'b1).
//  One sub-module: onehot_dec #(N) (log2 N -> N one-hot), instanced 7->128 and 3->8.
//  State/counter flops use the project dff cell with active-low async reset.
// TESTING
//  1 Reset: rst=0 mid-sim -> all strobes 0, fsm_busy=0, block_enable=128'h1; holds until rst=1.
//  2 Basic fill: miss_address=16'hABCD, memory latency 4 ->
//    - mem_en 8 cycles at 16'hABC0, ABC2 .. ABCE;
//    - 8 writes to block_enable bit 60, word_enable 01..80 in order;
//    - write_tag_array + fill_done in the 8th valid cycle with tag_out=5'h15;
//    - fsm_busy high from the miss cycle through the done cycle (12 cycles).
//  3 Miss re-asserted during FILL with 16'h1230 -> no effect; fill completes for 16'hABC0.
//  4 Back-to-back: second miss 16'h0010 the cycle after fill_done -> new fill, block_enable bit 1.
//  5 Reset after 3 valid words -> no tag write, IDLE; a new miss to the same set refills all 8 words.
//  6 Stray memory_data_valid=1 in IDLE -> write_data_array stays 0, recv_cnt stays 0.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Purpose : shared geometry, address field positions and FSM encoding for the cache fill path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Geometry: 16-bit byte address = tag[15:11] | index[10:4] | word offset[3:1] | byte[0].
package cache_fill_fsm_pkg;

    localparam int ADDR_W  = 16;
    localparam int WORDS   = 8;
    localparam int SETS    = 128;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 16;

    localparam int OFF_W   = $clog2(WORDS);   // 3
    localparam int IDX_W   = $clog2(SETS);    // 7
    localparam int OFF_LSB = 1;
    localparam int IDX_LSB = OFF_LSB + OFF_W; // 4
    localparam int TAG_LSB = IDX_LSB + IDX_W; // 11

    // Block address = tag + index, i.e. the byte address with offset and byte bits stripped.
    localparam int BLK_W   = ADDR_W - IDX_LSB; // 12

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Byte address of word 'off' inside block 'blk'.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0] blk,
                                                    input logic [OFF_W-1:0] off);
        return {blk, off, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_onehot_dec.sv
// Purpose : binary -> one-hot decoder, used for set (7->128) and word (3->8) enables.
// Latency : combinational.
// Backpressure: none.
// Ports   : sel (binary index), onehot (exactly one bit set at position sel).
module onehot_dec #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] sel,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Purpose : direct-mapped cache miss handler; fetches an 8-word block from pipelined memory,
//           writes each returned word into the data array, then writes the tag once the line is whole.
// Latency : stall is combinational in the miss cycle; each returned word is written on the edge it is valid.
// Backpressure: none toward memory (reads issued back-to-back); pipeline held via fsm_busy for the whole fill.
// Ports   : clk/rst (async active-low); miss_detected/miss_address from the pipeline;
//           mem_en/memory_address/memory_data/memory_data_valid to main memory;
//           write_data_array/block_enable/word_enable/data_out to the data array;
//           write_tag_array/tag_out to the tag array; fsm_busy stall; fill_done completion pulse.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic [DATA_W-1:0]   memory_data,
    input  logic                memory_data_valid,
    output logic                fsm_busy,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   memory_address,
    output logic                write_data_array,
    output logic [SETS-1:0]     block_enable,
    output logic [WORDS-1:0]    word_enable,
    output logic [DATA_W-1:0]   data_out,
    output logic                write_tag_array,
    output logic [TAG_W-1:0]    tag_out,
    output logic                fill_done
);

    state_t             state_q, state_d;
    // One extra bit so the counter can rest at WORDS once every read has been issued.
    logic [OFF_W:0]     issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [BLK_W-1:0]   blk_q, blk_d;

    logic [SETS-1:0]    set_oh;
    logic [WORDS-1:0]   word_oh;

    // Offset/byte bits of the miss address are irrelevant: the whole block is fetched.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^miss_address[IDX_LSB-1:0];

    onehot_dec #(.N(SETS)) u_set_dec (
        .sel    (blk_q[IDX_W-1:0]),
        .onehot (set_oh)
    );

    onehot_dec #(.N(WORDS)) u_word_dec (
        .sel    (recv_cnt_q),
        .onehot (word_oh)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            blk_q       <= blk_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        blk_d            = blk_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_enable      = '0;
        data_out         = '0;
        write_tag_array  = 1'b0;
        tag_out          = '0;
        fill_done        = 1'b0;
        // Set select is only qualified by write_data_array, so it may idle at the last index.
        block_enable     = set_oh;

        case (state_q)
            IDLE: begin
                // Returned data outside a fill is ignored.
                if (miss_detected) begin
                    fsm_busy = 1'b1;
                    blk_d    = miss_address[ADDR_W-1:IDX_LSB];
                    state_d  = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                // Memory is pipelined: issue every cycle regardless of returns.
                if (!issue_cnt_q[OFF_W]) begin
                    mem_en         = 1'b1;
                    memory_address = word_addr(blk_q, issue_cnt_q[OFF_W-1:0]);
                    issue_cnt_d    = issue_cnt_q + 1'b1;
                end

                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_enable      = word_oh;
                    data_out         = memory_data;
                    recv_cnt_d       = recv_cnt_q + 1'b1;

                    // Tag goes in only with the final word so a partial line never looks valid.
                    if (recv_cnt_q == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        tag_out         = blk_q[BLK_W-1 -: TAG_W];
                        fill_done       = 1'b1;
                        state_d         = IDLE;
                        issue_cnt_d     = '0;
                        recv_cnt_d      = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Purpose : directed self-checking bench for cache_fill_fsm.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_cache_fill_fsm;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [15:0]   miss_address;
    logic [15:0]   memory_data;
    logic          memory_data_valid;
    logic          fsm_busy;
    logic          mem_en;
    logic [15:0]   memory_address;
    logic          write_data_array;
    logic [127:0]  block_enable;
    logic [7:0]    word_enable;
    logic [15:0]   data_out;
    logic          write_tag_array;
    logic [4:0]    tag_out;
    logic          fill_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .block_enable      (block_enable),
        .word_enable       (word_enable),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array),
        .tag_out           (tag_out),
        .fill_done         (fill_done)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // strobes = {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}
    task automatic test_reset();
        rst = 1'b0; miss_detected = 1'b0; miss_address = 16'hABCD;
        memory_data_valid = 1'b1; memory_data = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== 5'b0) begin
                errors++; $display("FAIL reset_strobes k=%0d got=%b exp=00000", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done});
            end
            checks++;
            if (block_enable !== 128'h1) begin
                errors++; $display("FAIL reset_block_enable got=%h exp=1", block_enable);
            end
            checks++;
            if ({memory_address, word_enable, data_out, tag_out} !== 45'h0) begin
                errors++; $display("FAIL reset_buses addr=%h we=%h do=%h tag=%h exp all 0",
                    memory_address, word_enable, data_out, tag_out);
            end
        end
        next_cycle();
        rst = 1'b1; memory_data_valid = 1'b0; memory_data = 16'h0;
        next_cycle();
    endtask

    task automatic test_basic_fill();
        logic vld;
        logic [4:0] exp_s;
        logic [15:0] exp_addr, exp_do;
        logic [7:0] exp_we;
        logic [4:0] exp_tag;
        for (int k = 0; k <= 12; k++) begin
            vld = (k >= 4 && k <= 11);
            miss_detected = (k == 0);
            miss_address = (k == 0) ? 16'hABCD : 16'h0000;
            memory_data_valid = vld;
            memory_data = vld ? 16'hD000 + 16'(k - 4) : 16'hFFFF;
            exp_s = {(k <= 11), (k >= 1 && k <= 8), vld, (k == 11), (k == 11)};
            exp_addr = (k >= 1 && k <= 8) ? 16'hABC0 + 16'(2 * (k - 1)) : 16'h0;
            exp_we = vld ? 8'(1 << (k - 4)) : 8'h0;
            exp_do = vld ? 16'hD000 + 16'(k - 4) : 16'h0;
            exp_tag = (k == 11) ? 5'h15 : 5'h0;
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== exp_s) begin
                errors++; $display("FAIL basic_strobes k=%0d got=%b exp=%b", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}, exp_s);
            end
            checks++;
            if (memory_address !== exp_addr) begin
                errors++; $display("FAIL basic_addr k=%0d got=%h exp=%h", k, memory_address, exp_addr);
            end
            checks++;
            if (word_enable !== exp_we || data_out !== exp_do) begin
                errors++; $display("FAIL basic_word k=%0d we=%h do=%h exp we=%h do=%h",
                    k, word_enable, data_out, exp_we, exp_do);
            end
            checks++;
            if (tag_out !== exp_tag) begin
                errors++; $display("FAIL basic_tag k=%0d got=%h exp=%h", k, tag_out, exp_tag);
            end
            if (vld) begin
                checks++;
                if (block_enable !== (128'h1 << 60)) begin
                    errors++; $display("FAIL basic_block k=%0d got=%h exp bit 60", k, block_enable);
                end
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
    endtask

    // Miss held high through the fill with another address; returns overlap issue (valid 2..9).
    task automatic test_miss_in_fill();
        logic vld;
        logic [4:0] exp_s;
        logic [15:0] exp_addr;
        for (int k = 0; k <= 10; k++) begin
            vld = (k >= 2 && k <= 9);
            miss_detected = (k <= 9);
            miss_address = (k == 0) ? 16'hABCD : 16'h1230;
            memory_data_valid = vld;
            memory_data = 16'h3000 + 16'(k);
            exp_s = {(k <= 9), (k >= 1 && k <= 8), vld, (k == 9), (k == 9)};
            exp_addr = (k >= 1 && k <= 8) ? 16'hABC0 + 16'(2 * (k - 1)) : 16'h0;
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== exp_s) begin
                errors++; $display("FAIL refire_strobes k=%0d got=%b exp=%b", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}, exp_s);
            end
            checks++;
            if (memory_address !== exp_addr) begin
                errors++; $display("FAIL refire_addr k=%0d got=%h exp=%h", k, memory_address, exp_addr);
            end
            if (vld) begin
                checks++;
                if (block_enable !== (128'h1 << 60) || word_enable !== 8'(1 << (k - 2))) begin
                    errors++; $display("FAIL refire_write k=%0d be=%h we=%h exp bit 60 we=%h",
                        k, block_enable, word_enable, 8'(1 << (k - 2)));
                end
            end
            if (k == 9) begin
                checks++;
                if (tag_out !== 5'h15) begin
                    errors++; $display("FAIL refire_tag got=%h exp=15", tag_out);
                end
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
    endtask

    // Fill 0x4567 with gapped returns, then a new miss 0x0010 the cycle after fill_done.
    task automatic test_back_to_back();
        logic [23:0] vmask;
        logic vld, m_en;
        int widx;
        logic [4:0] exp_s;
        logic [15:0] exp_addr;
        logic [127:0] exp_be;
        vmask = 24'h7F9ED8;
        widx = 0;
        for (int k = 0; k <= 23; k++) begin
            vld = vmask[k];
            if (k == 13) widx = 0;
            miss_detected = (k == 0 || k == 13);
            miss_address = (k == 0) ? 16'h4567 : (k == 13) ? 16'h0010 : 16'h0000;
            memory_data_valid = vld;
            memory_data = 16'(k * 3 + 7);
            m_en = (k >= 1 && k <= 8) || (k >= 14 && k <= 21);
            exp_s = {(k <= 22), m_en, vld, (k == 12 || k == 22), (k == 12 || k == 22)};
            exp_addr = (k >= 1 && k <= 8) ? 16'h4560 + 16'(2 * (k - 1)) :
                       (k >= 14 && k <= 21) ? 16'h0010 + 16'(2 * (k - 14)) : 16'h0;
            exp_be = (k <= 12) ? (128'h1 << 86) : (128'h1 << 1);
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== exp_s) begin
                errors++; $display("FAIL b2b_strobes k=%0d got=%b exp=%b", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}, exp_s);
            end
            checks++;
            if (memory_address !== exp_addr) begin
                errors++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, memory_address, exp_addr);
            end
            if (vld) begin
                checks++;
                if (block_enable !== exp_be || word_enable !== 8'(1 << widx) ||
                    data_out !== 16'(k * 3 + 7)) begin
                    errors++; $display("FAIL b2b_write k=%0d be=%h we=%h do=%h exp be=%h we=%h do=%h",
                        k, block_enable, word_enable, data_out, exp_be, 8'(1 << widx), 16'(k * 3 + 7));
                end
                widx++;
            end
            if (k == 12 || k == 22) begin
                checks++;
                if (tag_out !== ((k == 12) ? 5'h08 : 5'h00)) begin
                    errors++; $display("FAIL b2b_tag k=%0d got=%h exp=%h", k, tag_out,
                        (k == 12) ? 5'h08 : 5'h00);
                end
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
    endtask

    // Reset after three returned words, then refill the same set from word 0.
    task automatic test_reset_mid_fill();
        logic vld;
        for (int k = 0; k <= 4; k++) begin
            vld = (k >= 2);
            miss_detected = (k == 0);
            miss_address = 16'h2345;
            memory_data_valid = vld;
            memory_data = 16'h7700 + 16'(k);
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !==
                {1'b1, (k >= 1), vld, 1'b0, 1'b0}) begin
                errors++; $display("FAIL partial_strobes k=%0d got=%b exp=%b", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done},
                    {1'b1, (k >= 1), vld, 1'b0, 1'b0});
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== 5'b0 ||
            block_enable !== 128'h1 || word_enable !== 8'h0) begin
            errors++; $display("FAIL midreset_outputs s=%b be=%h we=%h exp s=00000 be=1 we=0",
                {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}, block_enable, word_enable);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_tag_array} !== 3'b0 || memory_address !== 16'h0) begin
                errors++; $display("FAIL midreset_hold k=%0d s=%b addr=%h exp 000 / 0", k,
                    {fsm_busy, mem_en, write_tag_array}, memory_address);
            end
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        for (int k = 0; k <= 10; k++) begin
            vld = (k >= 2 && k <= 9);
            miss_detected = (k == 0);
            miss_address = 16'h234A;
            memory_data_valid = vld;
            memory_data = 16'h8800 + 16'(k);
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !==
                {(k <= 9), (k >= 1 && k <= 8), vld, (k == 9), (k == 9)}) begin
                errors++; $display("FAIL refill_strobes k=%0d got=%b exp=%b", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done},
                    {(k <= 9), (k >= 1 && k <= 8), vld, (k == 9), (k == 9)});
            end
            if (k == 1) begin
                checks++;
                if (memory_address !== 16'h2340) begin
                    errors++; $display("FAIL refill_first_addr got=%h exp=2340", memory_address);
                end
            end
            if (vld) begin
                checks++;
                if (block_enable !== (128'h1 << 52) || word_enable !== 8'(1 << (k - 2))) begin
                    errors++; $display("FAIL refill_write k=%0d be=%h we=%h exp bit 52 we=%h",
                        k, block_enable, word_enable, 8'(1 << (k - 2)));
                end
            end
            if (k == 9) begin
                checks++;
                if (tag_out !== 5'h04) begin
                    errors++; $display("FAIL refill_tag got=%h exp=04", tag_out);
                end
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
    endtask

    // Stray returns while idle, then a fill to the top set starting at word 0.
    task automatic test_stray_valid();
        logic vld;
        for (int k = 0; k < 3; k++) begin
            miss_detected = 1'b0;
            memory_data_valid = 1'b1;
            memory_data = 16'hBEEF;
            @(negedge clk);
            checks++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array, fill_done} !== 5'b0 ||
                word_enable !== 8'h0 || data_out !== 16'h0) begin
                errors++; $display("FAIL stray_idle k=%0d s=%b we=%h do=%h exp all 0", k,
                    {fsm_busy, mem_en, write_data_array, write_tag_array, fill_done}, word_enable, data_out);
            end
            next_cycle();
        end
        for (int k = 0; k <= 10; k++) begin
            vld = (k >= 2 && k <= 9);
            miss_detected = (k == 0);
            miss_address = 16'h7FFE;
            memory_data_valid = vld;
            memory_data = 16'h4400 + 16'(k);
            @(negedge clk);
            if (vld) begin
                checks++;
                if (!write_data_array || block_enable !== (128'h1 << 127) ||
                    word_enable !== 8'(1 << (k - 2)) || data_out !== 16'h4400 + 16'(k)) begin
                    errors++; $display("FAIL stray_fill k=%0d wr=%b be=%h we=%h do=%h exp 1 bit127 we=%h do=%h",
                        k, write_data_array, block_enable, word_enable, data_out,
                        8'(1 << (k - 2)), 16'h4400 + 16'(k));
                end
            end
            checks++;
            if ({write_tag_array, fill_done, fsm_busy} !== {(k == 9), (k == 9), (k <= 9)}) begin
                errors++; $display("FAIL stray_done k=%0d got=%b exp=%b", k,
                    {write_tag_array, fill_done, fsm_busy}, {(k == 9), (k == 9), (k <= 9)});
            end
            if (k == 9) begin
                checks++;
                if (tag_out !== 5'h0F) begin
                    errors++; $display("FAIL stray_tag got=%h exp=0f", tag_out);
                end
            end
            next_cycle();
        end
        miss_detected = 1'b0; memory_data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h0;
        memory_data = 16'h0;
        memory_data_valid = 1'b0;
        test_reset();
        test_basic_fill();
        test_miss_in_fill();
        test_back_to_back();
        test_reset_mid_fill();
        test_stray_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
